// File: rtl/iterative_variable_shifter.sv
// Sequential shifter: moves the operand one bit position per clock until the
// requested distance is covered, with valid/ready handshakes on both sides.
module iterative_variable_shifter #(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amount,
  input  logic          in_dir,
  input  logic          in_arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [N-1:0]  work;
  logic [N-1:0]  work_next;
  logic          dir;
  logic          arith;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    work_next = work;
    if (!dir) begin
      work_next = {work[N-2:0], 1'b0};
    end else if (arith) begin
      work_next = {work[N-1], work[N-1:1]};
    end else begin
      work_next = {1'b0, work[N-1:1]};
    end
  end

  // out_data is loaded only when entering DONE, so it survives the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      dir      <= 1'b0;
      arith    <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work  <= in_data;
            cnt   <= in_amount;
            dir   <= in_dir;
            arith <= in_arith;
            if (in_amount == '0) begin
              out_data <= in_data;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            out_data <= work_next;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_variable_shifter.sv
// Self-checking bench for iterative_variable_shifter: directed scenarios plus a
// randomized run scored against the language shift operators.
module tb_iterative_variable_shifter;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [AW-1:0] in_amount;
  logic          in_dir;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iterative_variable_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int s,
                                         input logic d, input logic ar);
    logic signed [N-1:0] sa;
    sa = a;
    if (!d) return a << s;
    if (ar) return sa >>> s;
    return a >> s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand, then counts cycles (acceptance edge = 1) until out_valid.
  task automatic run_op(input logic [N-1:0] d, input int amt, input logic dr,
                        input logic ar, output int lat, output bit rdy_seen);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = AW'(amt);
    in_dir    = dr;
    in_arith  = ar;
    tick();
    in_valid  = 1'b0;
    in_data   = N'($urandom);
    in_amount = AW'($urandom_range(0, N - 1));
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 64) begin
      rdy_seen |= in_ready;
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_amount = AW'(2);
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ignored_input: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_left();
    int lat;
    bit rs;
    run_op(8'b1011_0110, 3, 1'b0, 1'b0, lat, rs);
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL left_latency: got %0d want 4", lat); end
    total++;
    if (rs !== 1'b0) begin bad++; $display("[TB] FAIL left_in_ready_busy: got %b want 0", rs); end
    total++;
    if (out_data !== 8'b1011_0000) begin bad++; $display("[TB] FAIL left_result: got %h want b0", out_data); end
    release_result();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL left_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_right();
    int lat;
    bit rs;
    run_op(8'b1011_0110, 3, 1'b1, 1'b0, lat, rs);
    total++;
    if (out_data !== 8'b0001_0110 || lat !== 4) begin
      bad++; $display("[TB] FAIL right_logical: got %h lat %0d want 16 lat 4", out_data, lat);
    end
    release_result();
    run_op(8'b1011_0110, 3, 1'b1, 1'b1, lat, rs);
    total++;
    if (out_data !== 8'b1111_0110 || lat !== 4) begin
      bad++; $display("[TB] FAIL right_arith_neg: got %h lat %0d want f6 lat 4", out_data, lat);
    end
    release_result();
    run_op(8'h35, 2, 1'b1, 1'b1, lat, rs);
    total++;
    if (out_data !== 8'h0D || lat !== 3) begin
      bad++; $display("[TB] FAIL right_arith_pos: got %h lat %0d want 0d lat 3", out_data, lat);
    end
    release_result();
  endtask

  task automatic test_amount_bounds();
    int lat;
    bit rs;
    run_op(8'hA5, 0, 1'b0, 1'b0, lat, rs);
    total++;
    if (out_data !== 8'hA5 || lat !== 1) begin
      bad++; $display("[TB] FAIL amount_zero: got %h lat %0d want a5 lat 1", out_data, lat);
    end
    release_result();
    run_op(8'hFF, 7, 1'b0, 1'b0, lat, rs);
    total++;
    if (out_data !== 8'h80 || lat !== 8) begin
      bad++; $display("[TB] FAIL amount_max: got %h lat %0d want 80 lat 8", out_data, lat);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    bit rs;
    bit stray;
    run_op(8'h5A, 2, 1'b1, 1'b1, lat, rs);
    total++;
    if (out_data !== 8'h16) begin bad++; $display("[TB] FAIL bp_result: got %h want 16", out_data); end
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      in_amount = AW'(1);
      in_dir    = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h16) begin
        bad++;
        $display("[TB] FAIL bp_hold: out_valid=%b in_ready=%b out_data=%h want 1/0/16",
                 out_valid, in_ready, out_data);
      end
    end
    in_valid = 1'b0;
    release_result();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h16) begin
      bad++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b out_data=%h want 0/1/16",
               out_valid, in_ready, out_data);
    end
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      stray |= out_valid;
    end
    total++;
    if (stray !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_accept: got stray result %b want 0", stray); end
  endtask

  task automatic test_reset_mid();
    bit stray;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    in_amount = AW'(6);
    in_dir    = 1'b0;
    in_arith  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL midreset_state: out_valid=%b in_ready=%b out_data=%h want 0/1/00",
               out_valid, in_ready, out_data);
    end
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      stray |= out_valid;
    end
    total++;
    if (stray !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stale: got %b want 0", stray); end
  endtask

  task automatic test_random();
    logic [N-1:0] q[$];
    logic [N-1:0] want;
    logic [N-1:0] held_data;
    bit held;
    bit acc;
    bit xfer;
    int accepted;
    int results;
    int cycles;
    accepted = 0;
    results  = 0;
    cycles   = 0;
    held     = 1'b0;
    held_data = '0;
    while ((accepted < 500 || q.size() != 0) && cycles < 40000) begin
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          bad++;
          $display("[TB] FAIL rand_stable: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, held_data);
        end
      end
      if (accepted < 500) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = N'($urandom);
        in_amount = AW'($urandom_range(0, N - 1));
        in_dir    = 1'($urandom_range(0, 1));
        in_arith  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        results++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand_extra_result: got %h want none", out_data);
        end else begin
          want = q.pop_front();
          if (out_data !== want) begin
            bad++;
            $display("[TB] FAIL rand_result: got %h want %h", out_data, want);
          end
        end
      end
      if (acc) begin
        q.push_back(model(in_data, int'(in_amount), in_dir, in_arith));
        accepted++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (cycles >= 40000) begin bad++; $display("[TB] FAIL rand_timeout: got %0d cycles want < 40000", cycles); end
    total++;
    if (results !== accepted || accepted !== 500) begin
      bad++; $display("[TB] FAIL rand_count: got %0d results for %0d operands want 500/500", results, accepted);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_dir    = 1'b0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_left();
    test_right();
    test_amount_bounds();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
